// File: rtl/shared_imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter slice.
// Port ids travel through the response pipeline in a fixed-width field.
package shared_imem_pkg;

   localparam int unsigned PORT_ID_MAX_W = 8;
   localparam int unsigned MAX_PORTS     = 1 << PORT_ID_MAX_W;

   // Width of a port index: clog2 of the port count, never below 1.
   function automatic int unsigned port_id_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // (base + off) mod n, valid while base < n and off <= n.
   function automatic int unsigned wrap_idx(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      int unsigned s;
      s = base + off;
      return (s >= n) ? s - n : s;
   endfunction

   typedef struct packed {
      logic                     valid;
      logic [PORT_ID_MAX_W-1:0] port_id;
   } imem_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant among requesting ports, round-robin from a rotating pointer
// or fixed priority with port 0 highest. Grant is combinational.
module rr_arbiter
   import shared_imem_pkg::*;
#(
   parameter int unsigned nPorts        = 3,
   parameter bit          fixedPriority = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [nPorts-1:0]                req,
   output logic [nPorts-1:0]                gnt,
   output logic [port_id_width(nPorts)-1:0] gnt_id
);

   localparam int unsigned PW = port_id_width(nPorts);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic          any_gnt;

   // Walk priority slots from highest to lowest; first requester in slot order wins.
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      any_gnt = 1'b0;
      for (int unsigned o = 0; o < nPorts; o++) begin
         for (int unsigned j = 0; j < nPorts; j++) begin
            if (rst && !any_gnt && req[j] &&
                (j == (fixedPriority ? o : wrap_idx(32'(ptr_q), o, nPorts)))) begin
               gnt[j]  = 1'b1;
               gnt_id  = PW'(j);
               any_gnt = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (fixedPriority) begin
         ptr_d = '0;
      end else if (any_gnt) begin
         ptr_d = PW'(wrap_idx(32'(gnt_id), 1, nPorts));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/shared_imem_arbiter.sv
// Lets nPorts cores share one pipelined instruction memory: one fetch per
// cycle, response routed back to the requester memLatency cycles later.
module shared_imem_arbiter
   import shared_imem_pkg::*;
#(
   parameter int unsigned nPorts        = 3,
   parameter int unsigned addrWidth     = 32,
   parameter int unsigned dataWidth     = 32,
   parameter int unsigned memLatency    = 1,
   parameter bit          fixedPriority = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [nPorts-1:0]           req,
   input  logic [nPorts*addrWidth-1:0] addr,
   output logic [nPorts-1:0]           gnt,
   output logic [nPorts-1:0]           rvalid,
   output logic [dataWidth-1:0]        rdata,
   output logic                        mem_req,
   output logic [addrWidth-1:0]        mem_addr,
   input  logic [dataWidth-1:0]        mem_rdata
);

   localparam int unsigned PW = port_id_width(nPorts);

   if (nPorts < 1 || nPorts > MAX_PORTS || memLatency < 1) begin : g_bad_cfg
      $error("shared_imem_arbiter: unsupported nPorts/memLatency");
   end

   logic [PW-1:0] gnt_id;
   imem_resp_t    pipe_q [memLatency];
   imem_resp_t    pipe_d [memLatency];
   imem_resp_t    tail;

   rr_arbiter #(
      .nPorts        (nPorts),
      .fixedPriority (fixedPriority)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      mem_req  = rst & (|req);
      mem_addr = '0;
      for (int unsigned j = 0; j < nPorts; j++) begin
         if (gnt[j]) begin
            mem_addr = addr[j*addrWidth +: addrWidth];
         end
      end
   end

   // Stage 0 captures this cycle's fetch; the tail lines up with mem_rdata.
   always_comb begin
      pipe_d[0] = '{valid: mem_req, port_id: PORT_ID_MAX_W'(gnt_id)};
      for (int unsigned i = 1; i < memLatency; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < memLatency; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < memLatency; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign tail = pipe_q[memLatency-1];

   always_comb begin
      rvalid = '0;
      for (int unsigned j = 0; j < nPorts; j++) begin
         rvalid[j] = rst && tail.valid && (tail.port_id == PORT_ID_MAX_W'(j));
      end
   end

   assign rdata = mem_rdata;

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
   a_gnt_subset : assert property (@(posedge clk) disable iff (!rst) (gnt & ~req) == '0);

endmodule
